// File: rtl/datapath_pkg.sv
// Shared datapath types for the matrix load/store unit: scalar widths,
// queue entry layout, FSM states and the scratchpad request bundle.
package datapath_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned MATBITS_W = 4;
  localparam int unsigned IMM_W     = 11;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [MATBITS_W-1:0] matbits_t;

  typedef enum logic {
    M_LOAD  = 1'b0,
    M_STORE = 1'b1
  } matrix_mem_t;

  typedef enum logic [1:0] {
    MLS_IDLE = 2'd0,
    MLS_REQ  = 2'd1,
    MLS_WAIT = 2'd2,
    MLS_DONE = 2'd3
  } mls_state_e;

  typedef struct packed {
    matrix_mem_t      mem_type;
    matbits_t         rd;
    logic [IMM_W-1:0] imm;
    word_t            addr;
    word_t            stride;
  } mls_entry_t;

  typedef struct packed {
    logic             done;
    logic [1:0]       ls_out;
    matbits_t         rd_out;
    logic [IMM_W-1:0] imm_out;
    word_t            address;
    word_t            stride_out;
  } matrix_ls_t;

  localparam logic [1:0] MLS_LS_LOAD  = 2'b10;
  localparam logic [1:0] MLS_LS_STORE = 2'b01;

  function automatic word_t sext_imm(input logic [IMM_W-1:0] v);
    return word_t'({{(WORD_W-IMM_W){v[IMM_W-1]}}, v});
  endfunction

endpackage

// File: rtl/fu_matrix_ls_fifo.sv
// Synchronous FIFO of matrix load/store entries; head is the oldest entry.
module fu_matrix_ls_fifo
  import datapath_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  mls_entry_t               din,
  output mls_entry_t               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  mls_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fu_matrix_ls.sv
// Matrix load/store unit: queues issued LD/ST ops, presents one request at a
// time to the scratchpad and pulses done back to issue on completion.
module fu_matrix_ls
  import datapath_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  matrix_mem_t      mem_type,
  input  matbits_t         rd,
  input  word_t            rdat1,
  input  word_t            rdat2,
  input  logic [IMM_W-1:0] imm,
  output logic             ready,
  input  logic             spad_ack,
  input  logic             spad_done,
  output matrix_ls_t       mls,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  mls_state_e       state;
  mls_state_e       state_next;
  mls_entry_t       entry_in;
  mls_entry_t       head;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign ready = !full;
  assign push  = en && ready;
  assign pop   = (state == MLS_DONE);

  always_comb begin
    entry_in          = '0;
    entry_in.mem_type = mem_type;
    entry_in.rd       = rd;
    entry_in.imm      = imm;
    entry_in.addr     = rdat1 + sext_imm(imm);
    entry_in.stride   = rdat2;
  end

  fu_matrix_ls_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (CLK),
    .rst  (RST),
    .push (push),
    .pop  (pop),
    .din  (entry_in),
    .head (head),
    .count(count),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= MLS_IDLE;
    else     state <= state_next;
  end

  // count still includes the head being popped in DONE.
  always_comb begin
    state_next = state;
    case (state)
      MLS_IDLE: if (!empty || push) state_next = MLS_REQ;
      MLS_REQ: begin
        if (spad_ack && spad_done) state_next = MLS_DONE;
        else if (spad_ack)         state_next = MLS_WAIT;
      end
      MLS_WAIT: if (spad_done) state_next = MLS_DONE;
      MLS_DONE: begin
        if (count > CNT_W'(1) || push) state_next = MLS_REQ;
        else                           state_next = MLS_IDLE;
      end
      default: state_next = MLS_IDLE;
    endcase
  end

  always_comb begin
    mls  = '0;
    busy = (state != MLS_IDLE) || !empty;
    if (state != MLS_IDLE) begin
      mls.rd_out     = head.rd;
      mls.imm_out    = head.imm;
      mls.address    = head.addr;
      mls.stride_out = head.stride;
    end
    case (state)
      MLS_REQ:  mls.ls_out = (head.mem_type == M_LOAD) ? MLS_LS_LOAD : MLS_LS_STORE;
      MLS_DONE: mls.done   = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_fu_matrix_ls.sv
// Directed bench for fu_matrix_ls: single-op vector table plus hand-written
// queueing, back-to-back and reset-in-flight sequences.
module tb_fu_matrix_ls;
  import datapath_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        en;
  matrix_mem_t mem_type;
  matbits_t    rd;
  word_t       rdat1;
  word_t       rdat2;
  logic [10:0] imm;
  logic        ready;
  logic        spad_ack;
  logic        spad_done;
  matrix_ls_t  mls;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  fu_matrix_ls #(.DEPTH(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .en       (en),
    .mem_type (mem_type),
    .rd       (rd),
    .rdat1    (rdat1),
    .rdat2    (rdat2),
    .imm      (imm),
    .ready    (ready),
    .spad_ack (spad_ack),
    .spad_done(spad_done),
    .mls      (mls),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!RST) begin
      assert (!(en && !ready)) else $error("FAIL issue_protocol: en asserted while ready=0");
    end
  end

  typedef struct {
    matrix_mem_t mt;
    logic [3:0]  r;
    logic [31:0] base;
    logic [31:0] stride;
    logic [10:0] im;
    logic [1:0]  exp_ls;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input matrix_mem_t mt, input logic [3:0] r, input logic [31:0] b,
                       input logic [31:0] s, input logic [10:0] i);
    en       = 1'b1;
    mem_type = mt;
    rd       = r;
    rdat1    = b;
    rdat2    = s;
    imm      = i;
  endtask

  task automatic spad(input logic a, input logic d);
    spad_ack  = a;
    spad_done = d;
  endtask

  initial begin
    vecs[0] = '{M_STORE, 4'd5,  32'h0000_0004, 32'h0000_0008, 11'h7F8, 2'b01, 32'hFFFF_FFFC};
    vecs[1] = '{M_LOAD,  4'd15, 32'hFFFF_FFFF, 32'h0000_0000, 11'h001, 2'b10, 32'h0000_0000};
    vecs[2] = '{M_STORE, 4'd0,  32'h8000_0000, 32'h0000_0100, 11'h400, 2'b01, 32'h7FFF_FC00};
    vecs[3] = '{M_LOAD,  4'd9,  32'h1234_5678, 32'h0000_0010, 11'h3FF, 2'b10, 32'h1234_5A77};
    vecs[4] = '{M_LOAD,  4'd12, 32'h0000_2000, 32'hDEAD_BEEF, 11'h000, 2'b10, 32'h0000_2000};

    RST = 1'b1; en = 1'b0; mem_type = M_LOAD; rd = '0; rdat1 = '0; rdat2 = '0; imm = '0;
    spad_ack = 1'b0; spad_done = 1'b0;
    step();
    step();
    chk("rst_mls_zero", 64'(|mls), 64'h0);
    chk("rst_ready",    64'(ready), 64'h1);
    chk("rst_busy",     64'(busy),  64'h0);
    RST = 1'b0;
    step();

    // First LOAD: ack at E1, done at E2, stray done-without-ack in REQ ignored.
    issue(M_LOAD, 4'd3, 32'h1000, 32'h40, 11'h010);
    step();
    en = 1'b0;
    chk("a_req_ls",     64'(mls.ls_out),     64'h2);
    chk("a_req_addr",   64'(mls.address),    64'h1010);
    chk("a_req_stride", 64'(mls.stride_out), 64'h40);
    chk("a_req_rd",     64'(mls.rd_out),     64'h3);
    chk("a_req_imm",    64'(mls.imm_out),    64'h010);
    chk("a_req_busy",   64'(busy),           64'h1);
    spad(1'b0, 1'b1);
    step();
    chk("a_stray_done_ls", 64'(mls.ls_out), 64'h2);
    chk("a_stray_done",    64'(mls.done),   64'h0);
    spad(1'b1, 1'b0);
    step();
    chk("a_wait_ls",   64'(mls.ls_out),  64'h0);
    chk("a_wait_addr", 64'(mls.address), 64'h1010);
    chk("a_wait_done", 64'(mls.done),    64'h0);
    spad(1'b0, 1'b1);
    step();
    spad(1'b0, 1'b0);
    chk("a_done",    64'(mls.done),   64'h1);
    chk("a_done_rd", 64'(mls.rd_out), 64'h3);
    chk("a_done_ls", 64'(mls.ls_out), 64'h0);
    step();
    chk("a_idle_done", 64'(mls.done), 64'h0);
    chk("a_idle_busy", 64'(busy),     64'h0);
    chk("a_idle_mls",  64'(|mls),     64'h0);

    // Table: single op, ack+done in the same REQ cycle goes straight to DONE.
    for (int v = 0; v < 5; v++) begin
      issue(vecs[v].mt, vecs[v].r, vecs[v].base, vecs[v].stride, vecs[v].im);
      step();
      en = 1'b0;
      chk($sformatf("v%0d_ls", v),     64'(mls.ls_out),     64'(vecs[v].exp_ls));
      chk($sformatf("v%0d_addr", v),   64'(mls.address),    64'(vecs[v].exp_addr));
      chk($sformatf("v%0d_stride", v), 64'(mls.stride_out), 64'(vecs[v].stride));
      chk($sformatf("v%0d_imm", v),    64'(mls.imm_out),    64'(vecs[v].im));
      spad(1'b1, 1'b1);
      step();
      spad(1'b0, 1'b0);
      chk($sformatf("v%0d_done", v),    64'(mls.done),   64'h1);
      chk($sformatf("v%0d_done_rd", v), 64'(mls.rd_out), 64'(vecs[v].r));
      step();
      chk($sformatf("v%0d_idle_busy", v), 64'(busy), 64'h0);
    end

    // Three ops with the scratchpad stalled; third waits for ready.
    issue(M_LOAD, 4'd1, 32'h100, 32'h4, 11'h000);
    step();
    chk("b_ready_1", 64'(ready), 64'h1);
    issue(M_STORE, 4'd2, 32'h200, 32'h4, 11'h004);
    step();
    en = 1'b0;
    chk("b_ready_full", 64'(ready),       64'h0);
    chk("b_head_addr",  64'(mls.address), 64'h100);
    step();
    chk("b_hold_ready", 64'(ready),      64'h0);
    chk("b_hold_ls",    64'(mls.ls_out), 64'h2);
    spad(1'b1, 1'b1);
    step();
    spad(1'b0, 1'b0);
    chk("b_done1",       64'(mls.done),   64'h1);
    chk("b_done1_rd",    64'(mls.rd_out), 64'h1);
    chk("b_done1_ready", 64'(ready),      64'h0);
    step();
    chk("b_req2_done",  64'(mls.done),    64'h0);
    chk("b_req2_ls",    64'(mls.ls_out),  64'h1);
    chk("b_req2_addr",  64'(mls.address), 64'h204);
    chk("b_req2_ready", 64'(ready),       64'h1);
    issue(M_LOAD, 4'd7, 32'h300, 32'h8, 11'h7FF);
    spad(1'b1, 1'b0);
    step();
    en = 1'b0;
    spad(1'b0, 1'b0);
    chk("b_wait2_ready", 64'(ready),       64'h0);
    chk("b_wait2_ls",    64'(mls.ls_out),  64'h0);
    chk("b_wait2_addr",  64'(mls.address), 64'h204);
    spad(1'b0, 1'b1);
    step();
    spad(1'b0, 1'b0);
    chk("b_done2",    64'(mls.done),   64'h1);
    chk("b_done2_rd", 64'(mls.rd_out), 64'h2);
    step();
    chk("b_req3_done", 64'(mls.done),    64'h0);
    chk("b_req3_ls",   64'(mls.ls_out),  64'h2);
    chk("b_req3_addr", 64'(mls.address), 64'h2FF);
    chk("b_req3_rd",   64'(mls.rd_out),  64'h7);
    spad(1'b1, 1'b1);
    step();
    spad(1'b0, 1'b0);
    chk("b_done3",    64'(mls.done),   64'h1);
    chk("b_done3_rd", 64'(mls.rd_out), 64'h7);
    step();
    chk("b_idle_busy", 64'(busy), 64'h0);

    // Enqueue in the same cycle as DONE pops the last entry.
    issue(M_STORE, 4'd4, 32'h10, 32'h8, 11'h020);
    step();
    en = 1'b0;
    chk("c_req_addr", 64'(mls.address), 64'h30);
    spad(1'b1, 1'b1);
    step();
    spad(1'b0, 1'b0);
    chk("c_doneA",       64'(mls.done),   64'h1);
    chk("c_doneA_rd",    64'(mls.rd_out), 64'h4);
    chk("c_doneA_ready", 64'(ready),      64'h1);
    issue(M_LOAD, 4'd6, 32'h1000, 32'h20, 11'h000);
    step();
    en = 1'b0;
    chk("c_reqB_done",  64'(mls.done),    64'h0);
    chk("c_reqB_ls",    64'(mls.ls_out),  64'h2);
    chk("c_reqB_addr",  64'(mls.address), 64'h1000);
    chk("c_reqB_rd",    64'(mls.rd_out),  64'h6);
    chk("c_reqB_ready", 64'(ready),       64'h1);
    spad(1'b1, 1'b1);
    step();
    spad(1'b0, 1'b0);
    chk("c_doneB_rd", 64'(mls.rd_out), 64'h6);
    step();
    chk("c_idle_busy", 64'(busy), 64'h0);

    // Reset during WAIT with two ops queued discards everything.
    issue(M_LOAD, 4'd8, 32'h40, 32'h4, 11'h000);
    step();
    issue(M_STORE, 4'd9, 32'h80, 32'h4, 11'h000);
    step();
    en = 1'b0;
    spad(1'b1, 1'b0);
    step();
    spad(1'b0, 1'b0);
    chk("d_wait_ls",   64'(mls.ls_out), 64'h0);
    chk("d_wait_busy", 64'(busy),       64'h1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("d_rst_mls",   64'(|mls),  64'h0);
    chk("d_rst_busy",  64'(busy),  64'h0);
    chk("d_rst_ready", 64'(ready), 64'h1);
    spad(1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step();
      spad(1'b0, 1'b0);
      chk($sformatf("d_after_done_%0d", c), 64'(mls.done), 64'h0);
      chk($sformatf("d_after_busy_%0d", c), 64'(busy),     64'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
